// File: rtl/sgt_serial_if.sv
// Serial compare bus: LSB-first operand bit pairs in, registered signed-compare flags out.
interface sgt_serial_if;
  logic start;
  logic bit_en;
  logic i0;
  logic i1;
  logic busy;
  logic valid;
  logic gt;
  logic eq;
  logic lt;

  modport master (
    output start, bit_en, i0, i1,
    input  busy, valid, gt, eq, lt
  );

  modport slave (
    input  start, bit_en, i0, i1,
    output busy, valid, gt, eq, lt
  );
endinterface

// File: rtl/sgt_serial.sv
// Bit-serial signed comparator, LSB-first; flags and valid land on the edge that samples the MSB.
// bit_en=0 stalls everything; start with bit_en restarts from bit 0 at any time.
module sgt_serial #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  sgt_serial_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          gt_run, gt_run_nxt;
  logic          eq_run, eq_run_nxt;
  logic          valid_q, valid_nxt;
  logic          gt_q, gt_nxt;
  logic          eq_q, eq_nxt;
  logic          lt_q, lt_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.bit_en && bus.start) state_nxt = SHIFT;
      SHIFT:   if (bus.bit_en && !bus.start && cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt    = cnt;
    gt_run_nxt = gt_run;
    eq_run_nxt = eq_run;
    valid_nxt  = 1'b0;
    gt_nxt     = gt_q;
    eq_nxt     = eq_q;
    lt_nxt     = lt_q;
    if (bus.bit_en) begin
      if (bus.start) begin
        // Bit 0 of a new pair; any operation in flight is dropped silently.
        gt_run_nxt = bus.i0 & ~bus.i1;
        eq_run_nxt = ~(bus.i0 ^ bus.i1);
        cnt_nxt    = CW'(1);
      end else if (state == SHIFT) begin
        if (cnt == LAST) begin
          // Sign bit: a differing MSB means the operand with the 0 is larger.
          if (bus.i0 != bus.i1) begin
            gt_nxt = bus.i1;
            lt_nxt = bus.i0;
            eq_nxt = 1'b0;
          end else begin
            gt_nxt = gt_run;
            eq_nxt = eq_run;
            lt_nxt = ~gt_run & ~eq_run;
          end
          valid_nxt = 1'b1;
          cnt_nxt   = '0;
        end else begin
          if (bus.i0 != bus.i1) begin
            gt_run_nxt = bus.i0;
            eq_run_nxt = 1'b0;
          end
          cnt_nxt = cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt     <= '0;
      gt_run  <= 1'b0;
      eq_run  <= 1'b1;
      valid_q <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b1;
      lt_q    <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      gt_run  <= gt_run_nxt;
      eq_run  <= eq_run_nxt;
      valid_q <= valid_nxt;
      gt_q    <= gt_nxt;
      eq_q    <= eq_nxt;
      lt_q    <= lt_nxt;
    end
  end

  always_comb begin
    bus.busy  = (state == SHIFT);
    bus.valid = valid_q;
    bus.gt    = gt_q;
    bus.eq    = eq_q;
    bus.lt    = lt_q;
  end

endmodule

// File: tb/tb_sgt_serial.sv
// Directed and exhaustive checks of sgt_serial at WIDTH=4 and WIDTH=2.
module tb_sgt_serial;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  sgt_serial_if if4 ();
  sgt_serial_if if2 ();

  sgt_serial #(.WIDTH(4)) dut4 (.clk(clk), .resetn(resetn), .bus(if4.slave));
  sgt_serial #(.WIDTH(2)) dut2 (.clk(clk), .resetn(resetn), .bus(if2.slave));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sx(input int v, input int w);
    return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
  endfunction

  task automatic get(input int w, output logic v, output logic bsy,
                     output logic g, output logic e, output logic l);
    if (w == 4) begin
      v = if4.valid; bsy = if4.busy; g = if4.gt; e = if4.eq; l = if4.lt;
    end else begin
      v = if2.valid; bsy = if2.busy; g = if2.gt; e = if2.eq; l = if2.lt;
    end
  endtask

  task automatic drive(input int w, input logic s, input logic en, input logic a, input logic b);
    if (w == 4) begin
      if4.start = s; if4.bit_en = en; if4.i0 = a; if4.i1 = b;
      if2.start = 1'b0; if2.bit_en = 1'b0; if2.i0 = 1'b0; if2.i1 = 1'b0;
    end else begin
      if2.start = s; if2.bit_en = en; if2.i0 = a; if2.i1 = b;
      if4.start = 1'b0; if4.bit_en = 1'b0; if4.i0 = 1'b0; if4.i1 = 1'b0;
    end
  endtask

  task automatic step(input int w, input logic s, input logic en, input logic a, input logic b);
    drive(w, s, en, a, b);
    @(posedge clk);
    #1;
    check("onehot4", (32'(if4.gt) + 32'(if4.eq) + 32'(if4.lt)) == 1, 1'b1);
    check("onehot2", (32'(if2.gt) + 32'(if2.eq) + 32'(if2.lt)) == 1, 1'b1);
  endtask

  task automatic send(input int w, input int a, input int b, input string tag);
    logic v, bsy, g, e, l;
    for (int i = 0; i < w; i++) begin
      step(w, i == 0, 1'b1, a[i], b[i]);
      get(w, v, bsy, g, e, l);
      if (i < w - 1) check({tag, "_early_valid"}, v, 1'b0);
    end
    check({tag, "_valid"}, v, 1'b1);
    check({tag, "_gt"}, g, sx(a, w) > sx(b, w));
    check({tag, "_eq"}, e, sx(a, w) == sx(b, w));
    check({tag, "_lt"}, l, sx(a, w) < sx(b, w));
  endtask

  logic v, bsy, g, e, l;
  int   a1, b1;

  initial begin
    resetn = 1'b0;
    drive(4, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(2, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    get(4, v, bsy, g, e, l);
    check("rst_valid", v, 1'b0); check("rst_busy", bsy, 1'b0);
    check("rst_gt", g, 1'b0); check("rst_eq", e, 1'b1); check("rst_lt", l, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Bits without start are ignored in IDLE.
    step(4, 1'b0, 1'b1, 1'b1, 1'b0);
    get(4, v, bsy, g, e, l);
    check("idle_ign_busy", bsy, 1'b0); check("idle_ign_valid", v, 1'b0);
    check("idle_ign_eq", e, 1'b1);

    // A=3, B=-2: busy only on cycles 2..4, pulse after the MSB.
    a1 = 3; b1 = 14;
    for (int i = 0; i < 4; i++) begin
      step(4, i == 0, 1'b1, a1[i], b1[i]);
      get(4, v, bsy, g, e, l);
      check("t1_busy", bsy, i < 3);
      check("t1_valid", v, i == 3);
    end
    check("t1_gt", g, 1'b1); check("t1_eq", e, 1'b0); check("t1_lt", l, 1'b0);
    step(4, 1'b0, 1'b0, 1'b0, 1'b0);
    get(4, v, bsy, g, e, l);
    check("t1_pulse_end", v, 1'b0); check("t1_gt_held", g, 1'b1);

    // A=-8, B=7 then -1,-1 back-to-back.
    send(4, 8, 7, "t2a");
    check("t2a_lt_direct", if4.lt, 1'b1);
    send(4, 15, 15, "t2b");
    check("t2b_eq_direct", if4.eq, 1'b1);

    // A=-3, B=-5 with a 3-cycle stall after bit 1.
    a1 = 13; b1 = 11;
    step(4, 1'b1, 1'b1, a1[0], b1[0]);
    step(4, 1'b0, 1'b1, a1[1], b1[1]);
    for (int i = 0; i < 3; i++) begin
      step(4, 1'b0, 1'b0, 1'b1, 1'b0);
      get(4, v, bsy, g, e, l);
      check("t3_stall_valid", v, 1'b0); check("t3_stall_busy", bsy, 1'b1);
    end
    step(4, 1'b0, 1'b1, a1[2], b1[2]);
    get(4, v, bsy, g, e, l);
    check("t3_bit2_valid", v, 1'b0);
    step(4, 1'b0, 1'b1, a1[3], b1[3]);
    get(4, v, bsy, g, e, l);
    check("t3_valid", v, 1'b1); check("t3_gt", g, 1'b1); check("t3_lt", l, 1'b0);

    // A=5, B=2 aborted at bit 2 by a restart with A=2, B=6.
    a1 = 5; b1 = 2;
    step(4, 1'b1, 1'b1, a1[0], b1[0]);
    step(4, 1'b0, 1'b1, a1[1], b1[1]);
    a1 = 2; b1 = 6;
    step(4, 1'b1, 1'b1, a1[0], b1[0]);
    get(4, v, bsy, g, e, l);
    check("t4_abort_valid", v, 1'b0); check("t4_abort_busy", bsy, 1'b1);
    check("t4_flags_held", g, 1'b1);
    for (int i = 1; i < 4; i++) begin
      step(4, 1'b0, 1'b1, a1[i], b1[i]);
      get(4, v, bsy, g, e, l);
      check("t4_valid", v, i == 3);
    end
    check("t4_lt", l, 1'b1); check("t4_gt", g, 1'b0);

    // Asynchronous reset in the middle of bit 2.
    a1 = 5; b1 = 1;
    step(4, 1'b1, 1'b1, a1[0], b1[0]);
    step(4, 1'b0, 1'b1, a1[1], b1[1]);
    drive(4, 1'b0, 1'b1, a1[2], b1[2]);
    #2;
    resetn = 1'b0;
    #1;
    get(4, v, bsy, g, e, l);
    check("t5_busy", bsy, 1'b0); check("t5_valid", v, 1'b0);
    check("t5_eq", e, 1'b1); check("t5_gt", g, 1'b0); check("t5_lt", l, 1'b0);
    drive(4, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b1;
    send(4, 7, 8, "t5_after");

    // Exhaustive at both widths.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        send(4, a, b, "exh4");
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        send(2, a, b, "exh2");

    step(4, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
